// File: rtl/tap_pkg.sv
// Shared definitions for the TAP controller slice: the 4-bit state codes
// and the 2-bit instruction codes decoded by the instruction register.
package tap_pkg;

    localparam int TAP_STATE_W = 4;

    typedef enum logic [TAP_STATE_W-1:0] {
        ST_EX2_DR   = 4'h0,
        ST_EX1_DR   = 4'h1,
        ST_SH_DR    = 4'h2,
        ST_PAUSE_DR = 4'h3,
        ST_SEL_IR   = 4'h4,
        ST_UPD_DR   = 4'h5,
        ST_CAP_DR   = 4'h6,
        ST_SEL_DR   = 4'h7,
        ST_EX2_IR   = 4'h8,
        ST_EX1_IR   = 4'h9,
        ST_SH_IR    = 4'hA,
        ST_PAUSE_IR = 4'hB,
        ST_RTI      = 4'hC,
        ST_UPD_IR   = 4'hD,
        ST_CAP_IR   = 4'hE,
        ST_TLR      = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        IR_BOUNDARY = 2'b00,
        IR_BYPASS   = 2'b01,
        IR_INTSCAN  = 2'b10,
        IR_BIST     = 2'b11
    } tap_instr_t;

endpackage

// File: rtl/tap_tdo_stage.sv
// Serial test-data output stage: muxes the IR or DR chain onto tdo while
// shifting and registers it together with its output enable.
// Ports:
//   clk, rst_l         test clock, synchronous active-low reset
//   i_shift_ir/dr      shift-state decodes from the TAP FSM
//   i_ir_tdo/i_dr_tdo  serial outputs of the IR and selected DR
//   o_tdo, o_tdo_en    registered serial output and enable
module tap_tdo_stage (
    input  logic clk,
    input  logic rst_l,
    input  logic i_shift_ir,
    input  logic i_shift_dr,
    input  logic i_ir_tdo,
    input  logic i_dr_tdo,
    output logic o_tdo,
    output logic o_tdo_en
);

    logic r_tdo;
    logic r_tdo_en;

    // tdo holds outside the shift states so the last shifted bit stays
    // visible through pause/exit.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            if (i_shift_ir) begin
                r_tdo <= i_ir_tdo;
            end else if (i_shift_dr) begin
                r_tdo <= i_dr_tdo;
            end
            r_tdo_en <= i_shift_ir | i_shift_dr;
        end
    end

    assign o_tdo    = r_tdo;
    assign o_tdo_en = r_tdo_en;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP state machine. Decodes TMS into IR/DR
// capture/shift/update levels, drives the test-logic reset and registers
// TDO through tap_tdo_stage. All control outputs decode the state register.
// Optional build macro: TAP_RTI_COUNT_EN adds rti_count, a saturating count
// of consecutive Run-Test/Idle cycles.
// Ports:
//   clk, rst_l                test clock, synchronous active-low reset
//   tms, ir_tdo, dr_tdo       mode select and serial chain outputs
//   state                     current TAP state code
//   test_rst_l                low in TEST_LOGIC_RESET
//   select_ir, capture_*, shift_*, update_*, run_idle   state decodes
//   tdo, tdo_en               registered serial output and enable
//   rti_count                 (TAP_RTI_COUNT_EN only) RTI cycle count
//
// state    | meaning
// TLR  F   | test-logic reset, test_rst_l low
// RTI  C   | run-test/idle
// SEL_DR 7 | select DR column
// CAP_DR 6 | capture into DR
// SH_DR  2 | shift DR, tdo from dr_tdo
// EX1_DR 1 | exit-1 DR
// PAU_DR 3 | pause DR
// EX2_DR 0 | exit-2 DR
// UPD_DR 5 | update DR
// SEL_IR 4 | select IR column
// CAP_IR E | capture into IR
// SH_IR  A | shift IR, tdo from ir_tdo
// EX1_IR 9 | exit-1 IR
// PAU_IR B | pause IR
// EX2_IR 8 | exit-2 IR
// UPD_IR D | update IR
module tap_controller
    import tap_pkg::*;
#(
    parameter int RTI_CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       tms,
    input  logic       ir_tdo,
    input  logic       dr_tdo,
    output logic [3:0] state,
    output logic       test_rst_l,
    output logic       select_ir,
    output logic       capture_ir,
    output logic       shift_ir,
    output logic       update_ir,
    output logic       capture_dr,
    output logic       shift_dr,
    output logic       update_dr,
    output logic       run_idle,
    output logic       tdo,
    output logic       tdo_en
`ifdef TAP_RTI_COUNT_EN
    ,
    output logic [RTI_CNT_W-1:0] rti_count
`endif
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state <= ST_TLR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_TLR:      w_next = tms ? ST_TLR      : ST_RTI;
            ST_RTI:      w_next = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   w_next = tms ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   w_next = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_SH_DR:    w_next = tms ? ST_EX1_DR   : ST_SH_DR;
            ST_EX1_DR:   w_next = tms ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: w_next = tms ? ST_EX2_DR   : ST_PAUSE_DR;
            ST_EX2_DR:   w_next = tms ? ST_UPD_DR   : ST_SH_DR;
            ST_UPD_DR:   w_next = tms ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   w_next = tms ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   w_next = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_SH_IR:    w_next = tms ? ST_EX1_IR   : ST_SH_IR;
            ST_EX1_IR:   w_next = tms ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: w_next = tms ? ST_EX2_IR   : ST_PAUSE_IR;
            ST_EX2_IR:   w_next = tms ? ST_UPD_IR   : ST_SH_IR;
            ST_UPD_IR:   w_next = tms ? ST_SEL_DR   : ST_RTI;
            default:     w_next = ST_TLR;
        endcase
    end

    assign state      = r_state;
    assign test_rst_l = (r_state != ST_TLR);
    assign select_ir  = r_state inside {ST_SEL_IR, ST_CAP_IR, ST_SH_IR, ST_EX1_IR,
                                        ST_PAUSE_IR, ST_EX2_IR, ST_UPD_IR};
    assign capture_ir = (r_state == ST_CAP_IR);
    assign shift_ir   = (r_state == ST_SH_IR);
    assign update_ir  = (r_state == ST_UPD_IR);
    assign capture_dr = (r_state == ST_CAP_DR);
    assign shift_dr   = (r_state == ST_SH_DR);
    assign update_dr  = (r_state == ST_UPD_DR);
    assign run_idle   = (r_state == ST_RTI);

    tap_tdo_stage u_tdo_stage (
        .clk        (clk),
        .rst_l      (rst_l),
        .i_shift_ir (shift_ir),
        .i_shift_dr (shift_dr),
        .i_ir_tdo   (ir_tdo),
        .i_dr_tdo   (dr_tdo),
        .o_tdo      (tdo),
        .o_tdo_en   (tdo_en)
    );

`ifdef TAP_RTI_COUNT_EN
    logic [RTI_CNT_W-1:0] r_rti_count;

    // The count reads the number of RTI cycles completed so far; the edge
    // that leaves RTI clears it so it reads 0 as soon as the FSM is out.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_rti_count <= '0;
        end else if (r_state == ST_RTI && w_next == ST_RTI) begin
            if (r_rti_count != '1) begin
                r_rti_count <= r_rti_count + 1'b1;
            end
        end else begin
            r_rti_count <= '0;
        end
    end

    assign rti_count = r_rti_count;
`endif

endmodule

// File: tb/tb_tap_controller.sv
module tb_tap_controller;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       tms = 1'b1;
    logic       ir_tdo = 1'b0;
    logic       dr_tdo = 1'b0;
    logic [3:0] state;
    logic       test_rst_l, select_ir, capture_ir, shift_ir, update_ir;
    logic       capture_dr, shift_dr, update_dr, run_idle, tdo, tdo_en;
`ifdef TAP_RTI_COUNT_EN
    logic [CW-1:0] rti_count;
`endif

    tap_controller #(.RTI_CNT_W(CW)) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .tms        (tms),
        .ir_tdo     (ir_tdo),
        .dr_tdo     (dr_tdo),
        .state      (state),
        .test_rst_l (test_rst_l),
        .select_ir  (select_ir),
        .capture_ir (capture_ir),
        .shift_ir   (shift_ir),
        .update_ir  (update_ir),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .run_idle   (run_idle),
        .tdo        (tdo),
        .tdo_en     (tdo_en)
`ifdef TAP_RTI_COUNT_EN
        ,
        .rti_count  (rti_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the transition table written as data, plus the
    // abstract TAP variables (state, last tdo, enable, RTI run length).
    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];
    logic [3:0] m_st;
    logic       m_tdo, m_en;
    int         m_cnt;
    bit         arc_hit [32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {test_rst_l, select_ir, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr, run_idle}
    function automatic logic [8:0] exp_dec(input logic [3:0] s);
        logic ir_col;
        ir_col = (s == 4'h4) || (s == 4'hE) || (s == 4'hA) || (s == 4'h9) ||
                 (s == 4'hB) || (s == 4'h8) || (s == 4'hD);
        return {s != 4'hF, ir_col, s == 4'hE, s == 4'hA, s == 4'hD,
                s == 4'h6, s == 4'h2, s == 4'h5, s == 4'hC};
    endfunction

    task automatic tick(input logic t, input logic ir, input logic dr, input logic rst);
        logic [3:0] prev;
        @(negedge clk);
        tms = t; ir_tdo = ir; dr_tdo = dr; rst_l = rst;
        @(posedge clk);
        if (!rst) begin
            m_st = 4'hF; m_tdo = 1'b0; m_en = 1'b0; m_cnt = 0;
        end else begin
            prev = m_st;
            if (prev == 4'hA) m_tdo = ir;
            else if (prev == 4'h2) m_tdo = dr;
            m_en = (prev == 4'hA) || (prev == 4'h2);
            if (prev == 4'hC && !t) m_cnt = (m_cnt == CMAX) ? m_cnt : m_cnt + 1;
            else m_cnt = 0;
            m_st = t ? nxt1[prev] : nxt0[prev];
            arc_hit[{prev, t}] = 1'b1;
        end
        #1;
        chk("state", 32'(state), 32'(m_st));
        chk("decode", 32'({test_rst_l, select_ir, capture_ir, shift_ir, update_ir,
                           capture_dr, shift_dr, update_dr, run_idle}), 32'(exp_dec(m_st)));
        chk("tdo", 32'(tdo), 32'(m_tdo));
        chk("tdo_en", 32'(tdo_en), 32'(m_en));
`ifdef TAP_RTI_COUNT_EN
        chk("rti_count", 32'(rti_count), 32'(m_cnt));
`endif
    endtask

    initial begin
        int hits;
        // state code : next on tms=0 / tms=1
        nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;
        nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
        nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;
        nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
        nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;
        nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
        nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;
        nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
        nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;
        nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
        nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;
        nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
        nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;
        nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
        nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;
        nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;
        m_st = 4'hF; m_tdo = 1'b0; m_en = 1'b0; m_cnt = 0;

        // Reset from SH_DR
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1); tick(1, 0, 0, 1); tick(0, 0, 0, 1); tick(0, 0, 1, 1);
        chk("pre_rst_state", 32'(state), 32'h2);
        tick(0, 0, 1, 0);
        chk("rst_state", 32'(state), 32'hF);
        chk("rst_test_rst_l", 32'(test_rst_l), 32'h0);
        chk("rst_tdo_en", 32'(tdo_en), 32'h0);
        tick(0, 0, 0, 1);
        chk("rst_exit_state", 32'(state), 32'hC);
        chk("rst_exit_run_idle", 32'(run_idle), 32'h1);

        // DR scan from TLR
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1); tick(1, 0, 0, 1); tick(0, 0, 0, 1); tick(0, 0, 0, 1);
        chk("dr_state", 32'(state), 32'h2);
        chk("dr_shift", 32'(shift_dr), 32'h1);
        begin
            logic [3:0] pat;
            pat = 4'b1011;
            for (int i = 0; i < 4; i++) begin
                tick(0, 0, pat[3-i], 1);
                chk("dr_tdo_bit", 32'(tdo), 32'(pat[3-i]));
                chk("dr_tdo_en", 32'(tdo_en), 32'h1);
            end
        end
        tick(1, 0, 0, 1); tick(1, 0, 0, 1);
        chk("dr_upd_state", 32'(state), 32'h5);
        chk("dr_upd", 32'(update_dr), 32'h1);
        tick(0, 0, 0, 1);
        chk("dr_upd_one_cycle", 32'(update_dr), 32'h0);

        // IR scan from RTI
        tick(1, 0, 0, 1); tick(1, 0, 0, 1); tick(0, 0, 0, 1); tick(0, 0, 0, 1);
        chk("ir_state", 32'(state), 32'hA);
        chk("ir_select", 32'(select_ir), 32'h1);
        chk("ir_shift", 32'(shift_ir), 32'h1);
        tick(0, 1, 0, 1); chk("ir_tdo_1", 32'(tdo), 32'h1);
        tick(0, 0, 1, 1); chk("ir_tdo_0", 32'(tdo), 32'h0);
        tick(1, 0, 0, 1); tick(1, 0, 0, 1);
        chk("ir_upd", 32'(update_ir), 32'h1);
        tick(0, 0, 0, 1);
        chk("ir_upd_one_cycle", 32'(update_ir), 32'h0);
        chk("ir_back_rti", 32'(state), 32'hC);

        // Pause/resume in DR column
        tick(1, 0, 0, 1); tick(0, 0, 0, 1); tick(0, 0, 0, 1);
        tick(0, 0, 1, 1);
        tick(1, 0, 0, 1);
        chk("pause_ex1", 32'(state), 32'h1);
        tick(0, 0, 1, 1);
        chk("pause_state", 32'(state), 32'h3);
        chk("pause_tdo_en", 32'(tdo_en), 32'h0);
        tick(0, 0, 1, 1);
        chk("pause_tdo_held", 32'(tdo), 32'h0);
        tick(1, 0, 1, 1);
        chk("pause_ex2", 32'(state), 32'h0);
        tick(0, 0, 1, 1);
        chk("pause_resume", 32'(state), 32'h2);

`ifdef TAP_RTI_COUNT_EN
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 1);
        chk("rti_count_10", 32'(rti_count), 32'd10);
        tick(1, 0, 0, 1);
        chk("rti_count_clear", 32'(rti_count), 32'd0);
        tick(1, 0, 0, 1); tick(1, 0, 0, 1); tick(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 1);
        chk("rti_count_sat", 32'(rti_count), 32'(CMAX));
`endif

        // Five tms=1 edges reach TLR from every state
        for (int s = 0; s < 16; s++) begin
            int guard;
            tick(1, 0, 0, 0);
            guard = 0;
            while (m_st != 4'(s) && guard < 400) begin
                tick(1'($urandom_range(0, 1)), 0, 0, 1);
                guard++;
            end
            chk("reach_state", 32'(state), 32'(s));
            for (int k = 0; k < 5; k++) tick(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);
            chk("tms5_to_tlr", 32'(state), 32'hF);
        end

        // Random walk, occasional reset
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 99) != 0));
        end

        hits = 0;
        for (int a = 0; a < 32; a++) if (arc_hit[a]) hits++;
        chk("arc_coverage", 32'(hits), 32'd32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
